usb_rx: RTL and testbench
=========================

// Module: usb_rx
// PURPOSE
//  USB full-speed receiver; mirror of usb_tx on the inbound path. Samples D+/D-, NRZI-decodes,
//  checks SYNC and PID, and assembles bytes LSB-first. Data payloads are written into
//  fifo_data_buffer via store_rx_packet_data. The decoded PID and packet status go to the
//  protocol controller.
// PARAMETERS
//  CLKS_PER_BIT  8   clk cycles per USB bit (matches usb_tx)
//  SAMPLE_PT     3   counter value at which a bit is sampled (mid-bit)
//  MAX_BYTES     64  max payload bytes per data packet (FIFO depth)
// PORTS
//  clk                   in   1  system clock
//  rst                   in   1  asynchronous, active-high reset
//  Dplus_in              in   1  raw bus D+
//  Dminus_in             in   1  raw bus D-
//  buffer_occupancy      in   7  FIFO fill level
//  rx_packet             out  4  last decoded PID: DATA0=0011 DATA1=1011 ACK=0010 NAK=1010, 0000=none
//  rx_transfer_active    out  1  high while a packet is being received
//  rx_data_ready         out  1  1-cycle pulse: valid data packet completed
//  rx_error              out  1  sticky packet error flag
//  flush                 out  1  1-cycle pulse: clear FIFO at start of data payload
//  store_rx_packet_data  out  1  1-cycle pulse: write rx_packet_data into FIFO
//  rx_packet_data        out  8  assembled byte, valid while store_rx_packet_data is high
// BEHAVIOUR
//  - Reset: all outputs 0; rx_packet=0000; FSM=IDLE; bit counter 0; prev-level register J (D+=1, D-=0).
//  - Input synchronisation: D+/D- pass through a 2-flop synchroniser. Decode latency is 2 clk
//    plus the sample offset.
//  - Bit timing: a mod-CLKS_PER_BIT counter restarts at 0 on every D+ transition. A bit is
//    sampled when the counter equals SAMPLE_PT.
//  - NRZI: sampled level equal to the previous bit's level -> 1; different -> 0. No bit
//    unstuffing (usb_tx does not stuff).
//  - SE0 is D+=0 and D-=0 at the sample point.
//  - FSM states: IDLE, SYNC, PID, DATA, EOP, EOP_IDLE, ERR_WAIT.
//    - IDLE: a D+ falling edge -> SYNC. On this edge: rx_transfer_active=1, rx_error=0, rx_packet=0000.
//    - SYNC: collect 8 bits; the byte must equal 0x80. Otherwise -> ERR_WAIT.
//    - PID: collect 8 bits; the low nibble is the PID and the high nibble must be its
//      complement. Only the 4 PIDs above are legal. Otherwise -> ERR_WAIT.
//      - If legal: rx_packet is updated.
//      - DATA0/DATA1: pulse flush for 1 cycle, then -> DATA.
//      - ACK/NAK: -> EOP.
//    - DATA:
//      - SE0 at bit index 0 of a byte -> EOP.
//      - SE0 at any other bit index -> ERR_WAIT.
//      - Each 8th bit: pulse store_rx_packet_data for 1 cycle with the byte. A byte is
//        complete when it is assembled LSB-first.
//      - If a byte completes while buffer_occupancy == MAX_BYTES: do not store; -> ERR_WAIT.
//    - EOP: requires 2 consecutive SE0 bit samples; the first may come from DATA.
//      - Any non-SE0 sample before the 2nd SE0 -> ERR_WAIT.
//      - After the 2nd SE0 -> EOP_IDLE.
//    - EOP_IDLE: one J bit. Then -> IDLE and rx_transfer_active=0.
//      - For a data packet, pulse rx_data_ready in the same cycle.
//      - A K at this sample -> ERR_WAIT.
//    - ERR_WAIT: rx_error=1 and rx_transfer_active=0.
//      - No stores are issued.
//      - Stay until an SE0 sample is followed by a J sample, then -> IDLE.
//      - rx_error stays high until the next SYNC edge.
//  - A data packet with 0 payload bytes is legal: flush is pulsed, rx_data_ready is pulsed,
//    and no store occurs.
//  - store_rx_packet_data and flush are never high in the same cycle.
//  - rst mid-packet: everything returns to reset values immediately. After release, the
//    block arms in IDLE.
// TESTING
//  - Drive the usb_tx waveform: SYNC, DATA0 PID 0xC3, byte 0x01, EOP
//    -> flush pulse; 1 store with 0x01; rx_packet=0011; rx_data_ready pulse after EOP_IDLE.
//  - DATA1 with bytes 0x01..0x40 (64 bytes), occupancy tracking the FIFO
//    -> 64 stores in order; rx_error=0; rx_data_ready=1 once.
//  - ACK (PID 0xD2) then NAK (0x5A)
//    -> rx_packet=0010, then 1010; no flush or store; rx_transfer_active drops after the idle bit.
//  - SYNC byte 0x81 -> rx_error=1 and ERR_WAIT.
//    PID 0xB3 (bad complement) -> rx_error=1 and no stores.
//    In both cases rx_error is cleared at the next valid SYNC edge.
//  - 65-byte payload with buffer_occupancy=64 at the 65th byte
//    -> no 65th store; rx_error=1; no rx_data_ready.
//  - SE0 at bit 3 of a data byte -> rx_error=1.
//    rst asserted mid-payload -> all outputs 0 on the same edge; the next clean ACK decodes correctly.

Source files
------------

// File: rtl/usb_rx.sv
// Full-speed USB receiver: synchronises D+/D-, recovers bit timing from D+ edges,
// NRZI-decodes, validates SYNC/PID and streams payload bytes LSB-first into the FIFO.
module usb_rx #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_PT    = 3,
  parameter int MAX_BYTES    = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Dplus_in,
  input  logic       Dminus_in,
  input  logic [6:0] buffer_occupancy,
  output logic [3:0] rx_packet,
  output logic       rx_transfer_active,
  output logic       rx_data_ready,
  output logic       rx_error,
  output logic       flush,
  output logic       store_rx_packet_data,
  output logic [7:0] rx_packet_data
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SYNC     = 3'd1;
  localparam logic [2:0] ST_PID      = 3'd2;
  localparam logic [2:0] ST_DATA     = 3'd3;
  localparam logic [2:0] ST_EOP      = 3'd4;
  localparam logic [2:0] ST_EOP_IDLE = 3'd5;
  localparam logic [2:0] ST_ERR_WAIT = 3'd6;

  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [2:0]    state;
  logic          dp_s1, dp_s2, dp_d;
  logic          dm_s1, dm_s2;
  logic [CW-1:0] clk_cnt;
  logic [CW-1:0] cnt_now;
  logic          dp_edge, dp_fall, sample, se0, is_j, nrzi_bit;
  logic          prev_dp;
  logic [6:0]    shift_q;
  logic [7:0]    byte_now;
  logic [2:0]    bit_idx;
  logic          eop_seen, is_data, err_se0;
  logic [3:0]    pid_lo, pid_hi;
  logic          pid_legal, pid_is_data;

  // The bit clock is recovered by restarting the phase counter on every D+ edge.
  assign dp_edge  = dp_s2 ^ dp_d;
  assign dp_fall  = dp_d & ~dp_s2;
  assign cnt_now  = dp_edge ? '0 : clk_cnt;
  assign sample   = (cnt_now == CW'(SAMPLE_PT));
  assign se0      = ~dp_s2 & ~dm_s2;
  assign is_j     = dp_s2 & ~dm_s2;
  assign nrzi_bit = (dp_s2 == prev_dp);
  assign byte_now = {nrzi_bit, shift_q};

  assign pid_lo      = byte_now[3:0];
  assign pid_hi      = byte_now[7:4];
  assign pid_is_data = (pid_lo == 4'b0011) || (pid_lo == 4'b1011);
  assign pid_legal   = (pid_hi == ~pid_lo) &&
                       (pid_is_data || pid_lo == 4'b0010 || pid_lo == 4'b1010);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= ST_IDLE;
      dp_s1                <= 1'b1;
      dp_s2                <= 1'b1;
      dp_d                 <= 1'b1;
      dm_s1                <= 1'b0;
      dm_s2                <= 1'b0;
      clk_cnt              <= '0;
      prev_dp              <= 1'b1;
      shift_q              <= '0;
      bit_idx              <= '0;
      eop_seen             <= 1'b0;
      is_data              <= 1'b0;
      err_se0              <= 1'b0;
      rx_packet            <= 4'b0000;
      rx_transfer_active   <= 1'b0;
      rx_data_ready        <= 1'b0;
      rx_error             <= 1'b0;
      flush                <= 1'b0;
      store_rx_packet_data <= 1'b0;
      rx_packet_data       <= 8'h00;
    end else begin
      dp_s1   <= Dplus_in;
      dp_s2   <= dp_s1;
      dp_d    <= dp_s2;
      dm_s1   <= Dminus_in;
      dm_s2   <= dm_s1;
      clk_cnt <= (cnt_now == CW'(CLKS_PER_BIT - 1)) ? '0 : cnt_now + 1'b1;

      flush                <= 1'b0;
      store_rx_packet_data <= 1'b0;
      rx_data_ready        <= 1'b0;
      if (sample) prev_dp <= dp_s2;
      if (state != ST_ERR_WAIT) err_se0 <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (dp_fall) begin
            state              <= ST_SYNC;
            rx_transfer_active <= 1'b1;
            rx_error           <= 1'b0;
            rx_packet          <= 4'b0000;
            bit_idx            <= '0;
            prev_dp            <= 1'b1;
          end
        end
        ST_SYNC: begin
          if (sample) begin
            shift_q <= byte_now[7:1];
            bit_idx <= bit_idx + 1'b1;
            if (se0 || (bit_idx == 3'd7 && byte_now != 8'h80)) begin
              state <= ST_ERR_WAIT; rx_error <= 1'b1; rx_transfer_active <= 1'b0;
            end else if (bit_idx == 3'd7) begin
              state <= ST_PID;
            end
          end
        end
        ST_PID: begin
          if (sample) begin
            shift_q <= byte_now[7:1];
            bit_idx <= bit_idx + 1'b1;
            if (se0 || (bit_idx == 3'd7 && !pid_legal)) begin
              state <= ST_ERR_WAIT; rx_error <= 1'b1; rx_transfer_active <= 1'b0;
            end else if (bit_idx == 3'd7) begin
              rx_packet <= pid_lo;
              is_data   <= pid_is_data;
              eop_seen  <= 1'b0;
              flush     <= pid_is_data;
              state     <= pid_is_data ? ST_DATA : ST_EOP;
            end
          end
        end
        ST_DATA: begin
          if (sample) begin
            if (se0) begin
              if (bit_idx == 3'd0) begin
                state    <= ST_EOP;
                eop_seen <= 1'b1;
              end else begin
                state <= ST_ERR_WAIT; rx_error <= 1'b1; rx_transfer_active <= 1'b0;
              end
            end else begin
              shift_q <= byte_now[7:1];
              bit_idx <= bit_idx + 1'b1;
              // A full FIFO turns the overflowing byte into a packet error.
              if (bit_idx == 3'd7) begin
                if (buffer_occupancy == 7'(MAX_BYTES)) begin
                  state <= ST_ERR_WAIT; rx_error <= 1'b1; rx_transfer_active <= 1'b0;
                end else begin
                  store_rx_packet_data <= 1'b1;
                  rx_packet_data       <= byte_now;
                end
              end
            end
          end
        end
        ST_EOP: begin
          if (sample) begin
            if (!se0) begin
              state <= ST_ERR_WAIT; rx_error <= 1'b1; rx_transfer_active <= 1'b0;
            end else if (eop_seen) begin
              state <= ST_EOP_IDLE;
            end else begin
              eop_seen <= 1'b1;
            end
          end
        end
        ST_EOP_IDLE: begin
          if (sample) begin
            if (is_j) begin
              state              <= ST_IDLE;
              rx_transfer_active <= 1'b0;
              rx_data_ready      <= is_data;
            end else begin
              state <= ST_ERR_WAIT; rx_error <= 1'b1; rx_transfer_active <= 1'b0;
            end
          end
        end
        ST_ERR_WAIT: begin
          rx_error           <= 1'b1;
          rx_transfer_active <= 1'b0;
          if (sample) begin
            if (se0)                 err_se0 <= 1'b1;
            else if (is_j && err_se0) state  <= ST_IDLE;
            else                     err_se0 <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_rx.sv
// Bench for usb_rx: drives NRZI packets like usb_tx and checks against a packet-level
// reference model with a byte scoreboard.
module tb_usb_rx;

  localparam int CLKS      = 8;
  localparam int MAX_BYTES = 64;

  logic       tb_clk = 1'b0;
  logic       rst;
  logic       dp, dm;
  logic [6:0] occ;
  logic [3:0] rx_packet;
  logic       rx_transfer_active, rx_data_ready, rx_error, flush, store;
  logic [7:0] rx_packet_data;

  usb_rx dut (
    .clk                  (tb_clk),
    .rst                  (rst),
    .Dplus_in             (dp),
    .Dminus_in            (dm),
    .buffer_occupancy     (occ),
    .rx_packet            (rx_packet),
    .rx_transfer_active   (rx_transfer_active),
    .rx_data_ready        (rx_data_ready),
    .rx_error             (rx_error),
    .flush                (flush),
    .store_rx_packet_data (store),
    .rx_packet_data       (rx_packet_data)
  );

  always #5 tb_clk = ~tb_clk;

  int         n_checks = 0;
  int         n_errors = 0;
  int         flush_cnt = 0;
  int         ready_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] payload[0:127];
  logic       level;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_bit(input logic p, input logic m);
    dp = p;
    dm = m;
    repeat (CLKS) @(posedge tb_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      if (!b[i]) level = ~level;
      drive_bit(level, ~level);
    end
  endtask

  task automatic send_se0(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b0, 1'b0);
  endtask

  task automatic send_j(input int n);
    level = 1'b1;
    for (int i = 0; i < n; i++) drive_bit(1'b1, 1'b0);
  endtask

  // ---------------- reference model ----------------
  task automatic model_packet(input logic [7:0] sync, input logic [7:0] pid, input int nbytes,
                              input int se0_bit, output logic exp_err, output logic [3:0] exp_pkt,
                              output int exp_flush, output int exp_ready);
    logic [3:0] lo, hi;
    logic       data;
    lo = pid[3:0];
    hi = pid[7:4];
    exp_err = 1'b0; exp_pkt = 4'b0000; exp_flush = 0; exp_ready = 0;
    if (sync != 8'h80) exp_err = 1'b1;
    else if (hi != ~lo || !(lo == 4'h3 || lo == 4'hB || lo == 4'h2 || lo == 4'hA)) exp_err = 1'b1;
    else begin
      exp_pkt = lo;
      data = (lo == 4'h3 || lo == 4'hB);
      if (data) begin
        exp_flush = 1;
        for (int i = 0; i < nbytes; i++) begin
          if (i >= MAX_BYTES) begin exp_err = 1'b1; break; end
          exp_q.push_back(payload[i]);
        end
        if (se0_bit > 0) exp_err = 1'b1;
      end else if (nbytes > 0 || se0_bit > 0) begin
        exp_err = 1'b1;
      end
      if (!exp_err && data) exp_ready = 1;
    end
  endtask

  task automatic run_packet(input logic [7:0] sync, input logic [7:0] pid, input int nbytes,
                            input int se0_bit, input string tag);
    logic       exp_err;
    logic [3:0] exp_pkt;
    int         exp_flush, exp_ready;
    exp_q.delete();
    model_packet(sync, pid, nbytes, se0_bit, exp_err, exp_pkt, exp_flush, exp_ready);
    flush_cnt = 0;
    ready_cnt = 0;
    send_byte(sync, 8);
    if (sync == 8'h80) begin
      check({tag, "_active_mid"}, rx_transfer_active, 1);
      check({tag, "_err_cleared"}, rx_error, 0);
    end
    send_byte(pid, 8);
    for (int i = 0; i < nbytes; i++) send_byte(payload[i], 8);
    if (se0_bit > 0) send_byte(payload[nbytes], se0_bit);
    send_se0(2);
    send_j(4);
    check({tag, "_flush"}, flush_cnt, exp_flush);
    check({tag, "_ready"}, ready_cnt, exp_ready);
    check({tag, "_error"}, rx_error, exp_err);
    check({tag, "_pid"}, rx_packet, exp_pkt);
    check({tag, "_active_end"}, rx_transfer_active, 0);
    check({tag, "_stores_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    occ = '0;
    forever begin
      @(negedge tb_clk);
      if (rst) begin
        occ = '0;
      end else begin
        if (flush) begin
          flush_cnt++;
          occ = '0;
          check("flush_no_store", store, 0);
        end
        if (rx_data_ready) ready_cnt++;
        if (store) begin
          n_checks++;
          assert (exp_q.size() != 0) else begin
            n_errors++;
            $error("FAIL store_unexpected: observed data %0h, expected no store", rx_packet_data);
          end
          if (exp_q.size() != 0) check("store_data", rx_packet_data, exp_q.pop_front());
          occ = occ + 7'd1;
        end
      end
    end
  end

  initial begin
    #800000;
    $error("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b1; dp = 1'b1; dm = 1'b0; level = 1'b1;
    repeat (3) @(posedge tb_clk);
    #1;
    check("rst_pid", rx_packet, 0);
    check("rst_active", rx_transfer_active, 0);
    check("rst_ready", rx_data_ready, 0);
    check("rst_error", rx_error, 0);
    check("rst_flush", flush, 0);
    check("rst_store", store, 0);
    check("rst_data", rx_packet_data, 0);
    rst = 1'b0;
    send_j(4);

    payload[0] = 8'h01;
    run_packet(8'h80, 8'hC3, 1, 0, "data0_1byte");

    for (int i = 0; i < 64; i++) payload[i] = 8'(i + 1);
    run_packet(8'h80, 8'h4B, 64, 0, "data1_64");

    run_packet(8'h80, 8'hD2, 0, 0, "ack");
    run_packet(8'h80, 8'h5A, 0, 0, "nak");

    payload[0] = 8'h5C; payload[1] = 8'hA7;
    run_packet(8'h81, 8'hC3, 2, 0, "bad_sync");
    run_packet(8'h80, 8'hC3, 0, 0, "zero_len");
    run_packet(8'h80, 8'hB3, 2, 0, "bad_pid");
    run_packet(8'h80, 8'hD2, 0, 0, "ack_after_err");

    for (int i = 0; i < 65; i++) payload[i] = 8'(i + 1);
    run_packet(8'h80, 8'hC3, 65, 0, "overflow");

    payload[0] = 8'h3E; payload[1] = 8'hF0;
    run_packet(8'h80, 8'h4B, 1, 3, "se0_bit3");

    for (int k = 0; k < 6; k++) begin
      logic [7:0] pid;
      int         nb, sb;
      case ($urandom_range(0, 4))
        0:       pid = 8'hC3;
        1:       pid = 8'h4B;
        2:       pid = 8'hD2;
        3:       pid = 8'h5A;
        default: pid = 8'($urandom_range(0, 255));
      endcase
      nb = (pid == 8'hD2 || pid == 8'h5A) ? 0 : $urandom_range(0, 6);
      sb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      for (int i = 0; i <= nb; i++) payload[i] = 8'($urandom_range(0, 255));
      run_packet(8'h80, pid, nb, sb, "rand");
    end

    // Reset in the middle of a payload byte.
    exp_q.delete();
    for (int i = 0; i < 3; i++) payload[i] = 8'($urandom_range(0, 255));
    exp_q.push_back(payload[0]);
    exp_q.push_back(payload[1]);
    send_byte(8'h80, 8);
    send_byte(8'hC3, 8);
    send_byte(payload[0], 8);
    send_byte(payload[1], 8);
    send_byte(payload[2], 3);
    check("pre_rst_active", rx_transfer_active, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_pid", rx_packet, 0);
    check("mid_rst_active", rx_transfer_active, 0);
    check("mid_rst_error", rx_error, 0);
    check("mid_rst_flush", flush, 0);
    check("mid_rst_store", store, 0);
    check("mid_rst_data", rx_packet_data, 0);
    check("mid_rst_stores", exp_q.size(), 0);
    exp_q.delete();
    dp = 1'b1; dm = 1'b0; level = 1'b1;
    repeat (4) @(posedge tb_clk);
    #1;
    rst = 1'b0;
    send_j(4);
    run_packet(8'h80, 8'hD2, 0, 0, "ack_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
